if_id_reg: RTL and testbench

//   Fetch/decode pipeline register, directly downstream of the program counter.
//   - Captures the fetched PC and instruction word.
//   - Flags instruction-address exceptions (misaligned or out of range).
//   - Marks branch-delay-slot instructions.
//   - Supports stall (hold) and flush (bubble) from the hazard/exception controller.
//   - Presents registered D-stage values to the decoder.

---
 rtl/mips_pkg.sv | 14 +
 rtl/if_addr_chk.sv | 27 ++
 rtl/if_id_reg.sv | 133 +++++++++++++
 tb/tb_if_id_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: exception codes, the nop encoding and the default
// instruction-memory window used by the PC, fetch/decode register and address checkers.
package mips_pkg;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Instruction memory window, byte addresses, both ends inclusive
  localparam logic [31:0] IM_BASE_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_TOP_DEF  = 32'h0000_6FFF;

endpackage

// File: rtl/if_addr_chk.sv
// Combinational fetch-address checker: flags word-misaligned or out-of-window addresses.
// Reusable by the PC and data stages through the IM_BASE/IM_TOP parameters.
module if_addr_chk
  import mips_pkg::*;
#(
  parameter logic [31:0] IM_BASE = IM_BASE_DEF,
  parameter logic [31:0] IM_TOP  = IM_TOP_DEF
) (
  input  logic [31:0] pc,
  output logic        illegal
);

  // Start address of the last whole word that still fits below IM_TOP
  localparam logic [31:0] LAST_WORD = IM_TOP - 32'd3;

  logic misaligned;
  logic below_base;
  logic above_top;

  always_comb begin
    misaligned = |pc[1:0];
    below_base = (pc < IM_BASE);
    above_top  = (pc > LAST_WORD);
    illegal    = misaligned | below_base | above_top;
  end

endmodule

// File: rtl/if_id_reg.sv
// Fetch/decode pipeline register with fetch-address exception tagging, stall and flush.
// Optional saturating performance counters are built when IFID_PERF_CNT_EN is defined.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] IM_BASE = IM_BASE_DEF,
  parameter logic [31:0] IM_TOP  = IM_TOP_DEF,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      F_pc,
  input  logic [31:0]      F_instr,
  input  logic             F_bd,
  output logic [31:0]      D_pc,
  output logic [31:0]      D_instr,
  output logic             D_valid,
  output logic             D_bd,
  output logic [4:0]       D_exc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic        f_illegal;
  logic        load;

  logic [31:0] d_pc_q,    d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic        d_valid_q, d_valid_d;
  logic        d_bd_q,    d_bd_d;
  logic [4:0]  d_exc_q,   d_exc_d;

  if_addr_chk #(
    .IM_BASE (IM_BASE),
    .IM_TOP  (IM_TOP)
  ) u_addr_chk (
    .pc      (F_pc),
    .illegal (f_illegal)
  );

  assign load = !flush && !stall;

  always_comb begin
    d_pc_d    = d_pc_q;
    d_instr_d = d_instr_q;
    d_valid_d = d_valid_q;
    d_bd_d    = d_bd_q;
    d_exc_d   = d_exc_q;
    if (flush) begin
      // Bubble keeps the fetch PC so a later exception still has a meaningful address
      d_pc_d    = F_pc;
      d_instr_d = NOP_INSTR;
      d_valid_d = 1'b0;
      d_bd_d    = 1'b0;
      d_exc_d   = EXC_NONE;
    end else if (load) begin
      d_pc_d    = F_pc;
      d_bd_d    = F_bd;
      d_valid_d = 1'b1;
      d_instr_d = f_illegal ? NOP_INSTR : F_instr;
      d_exc_d   = f_illegal ? EXC_ADEL  : EXC_NONE;
    end
  end

  // F -> D stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_pc_q    <= IM_BASE;
      d_instr_q <= NOP_INSTR;
      d_valid_q <= 1'b0;
      d_bd_q    <= 1'b0;
      d_exc_q   <= EXC_NONE;
    end else begin
      d_pc_q    <= d_pc_d;
      d_instr_q <= d_instr_d;
      d_valid_q <= d_valid_d;
      d_bd_q    <= d_bd_d;
      d_exc_q   <= d_exc_d;
    end
  end

  assign D_pc    = d_pc_q;
  assign D_instr = d_instr_q;
  assign D_valid = d_valid_q;
  assign D_bd    = d_bd_q;
  assign D_exc   = d_exc_q;

`ifdef IFID_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != {CNT_W{1'b1}}))
      r = v + CNT_ONE;
    return r;
  endfunction

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, stall && !flush);
    flush_cnt_d = sat_inc(flush_cnt_q, flush);
    fetch_cnt_d = sat_inc(fetch_cnt_q, load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed and randomized bench for if_id_reg, checked against a behavioural model.
// Counters are built 4 bits wide so saturation is reachable; IFID_PERF_CNT_EN selects the model.
module tb_if_id_reg;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          flush;
  logic [31:0]   F_pc;
  logic [31:0]   F_instr;
  logic          F_bd;
  logic [31:0]   D_pc;
  logic [31:0]   D_instr;
  logic          D_valid;
  logic          D_bd;
  logic [4:0]    D_exc;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_bd;
  logic [4:0]  m_exc;
  int          m_stalls;
  int          m_flushes;
  int          m_fetches;

  if_id_reg #(
    .IM_BASE (32'h0000_3000),
    .IM_TOP  (32'h0000_6FFF),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .F_pc      (F_pc),
    .F_instr   (F_instr),
    .F_bd      (F_bd),
    .D_pc      (D_pc),
    .D_instr   (D_instr),
    .D_valid   (D_valid),
    .D_bd      (D_bd),
    .D_exc     (D_exc),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h3000) && (a + 4 <= 32'h7000) && (a <= 32'hFFFF_FFFB);
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef IFID_PERF_CNT_EN
    return (n > 15) ? 32'd15 : n;
`else
    return (n >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'h3000; m_instr = 0; m_valid = 0; m_bd = 0; m_exc = 0;
    m_stalls = 0; m_flushes = 0; m_fetches = 0;
  endtask

  task automatic model_edge(input logic fl, input logic st, input logic [31:0] pc,
                            input logic [31:0] ins, input logic bd);
    if (fl) begin
      m_pc = pc; m_instr = 0; m_valid = 0; m_bd = 0; m_exc = 0;
      m_flushes++;
    end else if (st) begin
      m_stalls++;
    end else begin
      m_pc = pc; m_bd = bd; m_valid = 1;
      m_instr = addr_ok(pc) ? ins : 32'h0;
      m_exc   = addr_ok(pc) ? 5'd0 : 5'd4;
      m_fetches++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".D_pc"},    D_pc, m_pc);
    check({tag, ".D_instr"}, D_instr, m_instr);
    check({tag, ".D_valid"}, {31'd0, D_valid}, {31'd0, m_valid});
    check({tag, ".D_bd"},    {31'd0, D_bd}, {31'd0, m_bd});
    check({tag, ".D_exc"},   {27'd0, D_exc}, {27'd0, m_exc});
    check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, exp_cnt(m_stalls));
    check({tag, ".flush_cnt"}, {28'd0, flush_cnt}, exp_cnt(m_flushes));
    check({tag, ".fetch_cnt"}, {28'd0, fetch_cnt}, exp_cnt(m_fetches));
  endtask

  // Apply inputs, take one rising edge, then compare just after it
  task automatic step(input string tag, input logic fl, input logic st,
                      input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    flush = fl; stall = st; F_pc = pc; F_instr = ins; F_bd = bd;
    @(posedge clk);
    model_edge(fl, st, pc, ins, bd);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; stall = 0; flush = 0; F_pc = 32'h3000; F_instr = 0; F_bd = 0;
    model_reset();
    #2;
    check_all("reset_init");
    #1 rst = 1'b0;

    // Load, then reset asserted mid-cycle while D_valid = 1
    step("pre_reset_load", 0, 0, 32'h3010, 32'h2408_0001, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    #1 rst = 1'b0;

    step("load", 0, 0, 32'h3004, 32'h3C01_1234, 1);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, 32'h4000 + 4 * i, $urandom, i[0]);
    check("stall3_cnt", {28'd0, stall_cnt}, exp_cnt(3));
    step("flush_over_stall", 1, 1, 32'h3008, 32'hDEAD_BEEF, 1);

    step("exc_misaligned", 0, 0, 32'h3002, 32'h1111_1111, 0);
    step("exc_above_top", 0, 0, 32'h7000, 32'h2222_2222, 1);
    step("last_word_ok", 0, 0, 32'h6FFC, 32'h3333_3333, 0);
    step("below_base", 0, 0, 32'h2FFC, 32'h4444_4444, 0);
    step("base_ok", 0, 0, 32'h3000, 32'h5555_5555, 1);
    step("top_minus2", 0, 0, 32'h6FFE, 32'h6666_6666, 0);
    step("all_ones_word", 0, 0, 32'hFFFF_FFFC, 32'h7777_7777, 0);

    // Long run of loads drives fetch_cnt into saturation
    for (int i = 0; i < 20; i++)
      step("sat_load", 0, 0, 32'h3100 + 4 * i, $urandom, 0);
    check("fetch_sat", {28'd0, fetch_cnt}, exp_cnt(99));

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 32'h3000 + 4 * $urandom_range(0, 32'hFFF);
        1:       rpc = $urandom;
        2:       rpc = 32'h6FF8 + $urandom_range(0, 15);
        default: rpc = 32'h2FF8 + $urandom_range(0, 15);
      endcase
      step("random", ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3),
           rpc, $urandom, 1'($urandom));
    end

    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("final_reset");
    #1 rst = 1'b0;
    step("post_reset_load", 0, 0, 32'h3020, 32'h8C01_0004, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
